// File: rtl/keypad_4x4_encoder.sv
// 4x4 matrix keypad scanner with debounce and release gating.
// Emits one 7-segment glyph, a digit/operator class bit and the raw key
// code for each physical key press, with a one-cycle strobe.
module keypad_4x4_encoder #(
    parameter int SCAN_HOLD   = 3,
    parameter int DEBOUNCE_MS = 20,
    parameter int RELEASE_MS  = 20
) (
    input  logic       clk1kHz,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [6:0] CSseg,
    output logic       tipo,
    output logic [3:0] codigo,
    output logic       tecla_valida
);

    // Shared debounce/release counter is sized for the larger threshold,
    // so it never has to wrap.
    localparam int CNT_MAX = (DEBOUNCE_MS > RELEASE_MS) ? DEBOUNCE_MS : RELEASE_MS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HOLD_W  = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0]  REL_LAST  = CNT_W'(RELEASE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        filas_m;
    logic [3:0]        filas_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        row;
    logic [1:0]        col;

    logic [1:0]        low_row;
    logic [1:0]        cur_col;
    logic [3:0]        next_cols;
    logic [3:0]        key_code;
    logic [6:0]        key_glyph;
    logic              key_mapped;
    logic              key_digit;

    // Key code for a (row, col) position on the pad.
    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'd1;   4'h1: k = 4'd2;   4'h2: k = 4'd3;   4'h3: k = 4'd10;
            4'h4: k = 4'd4;   4'h5: k = 4'd5;   4'h6: k = 4'd6;   4'h7: k = 4'd11;
            4'h8: k = 4'd7;   4'h9: k = 4'd8;   4'hA: k = 4'd9;   4'hB: k = 4'd12;
            4'hC: k = 4'd14;  4'hD: k = 4'd0;   4'hE: k = 4'd15;  default: k = 4'd13;
        endcase
        return k;
    endfunction

    // Active-low {a,b,c,d,e,f,g} glyph; * and # have no glyph and stay blank.
    function automatic logic [6:0] glyph_of(input logic [3:0] k);
        logic [6:0] g;
        case (k)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            4'd10:   g = 7'b1101100;  // '+'
            4'd11:   g = 7'b1111110;  // '-'
            4'd12:   g = 7'b1001000;  // '*'
            4'd13:   g = 7'b0110110;  // '/'
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        low_row = 2'd0;
        if (!filas_s[0])      low_row = 2'd0;
        else if (!filas_s[1]) low_row = 2'd1;
        else if (!filas_s[2]) low_row = 2'd2;
        else if (!filas_s[3]) low_row = 2'd3;
    end

    // Index of the column currently driven low, and the next one in rotation.
    always_comb begin
        cur_col = 2'd0;
        case (columnas)
            4'b1110: cur_col = 2'd0;
            4'b1101: cur_col = 2'd1;
            4'b1011: cur_col = 2'd2;
            4'b0111: cur_col = 2'd3;
            default: cur_col = 2'd0;
        endcase
        next_cols = {columnas[2:0], columnas[3]};
    end

    // Decode of the latched key position.
    always_comb begin
        key_code   = code_of(row, col);
        key_glyph  = glyph_of(key_code);
        key_mapped = (key_code != 4'd14) && (key_code != 4'd15);
        key_digit  = (key_code <= 4'd9);
    end

    // Two-flop synchronizer; idle rows read high.
    always_ff @(posedge clk1kHz or posedge rst) begin
        if (rst) begin
            filas_m <= 4'b1111;
            filas_s <= 4'b1111;
        end else begin
            filas_m <= filas;
            filas_s <= filas_m;
        end
    end

    // Scan / debounce / emit / release FSM with registered outputs.
    always_ff @(posedge clk1kHz or posedge rst) begin
        if (rst) begin
            state        <= SCAN;
            columnas     <= 4'b1110;
            hold_cnt     <= '0;
            cnt          <= '0;
            row          <= 2'd0;
            col          <= 2'd0;
            CSseg        <= 7'b1111111;
            tipo         <= 1'b0;
            codigo       <= 4'd0;
            tecla_valida <= 1'b0;
        end else begin
            tecla_valida <= 1'b0;
            case (state)
                SCAN: begin
                    // The last hold cycle sees rows that have settled
                    // through the synchronizer for this column.
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (filas_s != 4'b1111) begin
                            row   <= low_row;
                            col   <= cur_col;
                            cnt   <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            columnas <= next_cols;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (!filas_s[row]) begin
                        if (cnt == DEB_LAST) begin
                            cnt   <= '0;
                            state <= EMIT;
                            // Outputs land together with the strobe during EMIT.
                            if (key_mapped) begin
                                CSseg        <= key_glyph;
                                tipo         <= key_digit;
                                codigo       <= key_code;
                                tecla_valida <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: rescan the same column from the start.
                        cnt      <= '0;
                        hold_cnt <= '0;
                        state    <= SCAN;
                    end
                end

                EMIT: begin
                    cnt   <= '0;
                    state <= WAIT_RELEASE;
                end

                WAIT_RELEASE: begin
                    // Any low row restarts the release window, so a quick
                    // re-press merges into the press already reported.
                    if (filas_s == 4'b1111) begin
                        if (cnt == REL_LAST) begin
                            cnt      <= '0;
                            hold_cnt <= '0;
                            columnas <= next_cols;
                            state    <= SCAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                default: begin
                    state    <= SCAN;
                    columnas <= 4'b1110;
                    hold_cnt <= '0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_4x4_encoder.sv
// Directed bench for keypad_4x4_encoder: a keypad model drives rows from
// the pressed-key set and the DUT's columns; a monitor scores each strobe
// against a queue of expected glyphs.
module tb_keypad_4x4_encoder;

    logic       clk1kHz = 1'b0;
    logic       rst;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [6:0] CSseg;
    logic       tipo;
    logic [3:0] codigo;
    logic       tecla_valida;

    // keys[r*4+c] = 1 when the key at row r, column c is held down.
    logic [15:0] keys = '0;

    typedef struct packed {
        logic [6:0] seg;
        logic       tipo;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   checks = 0;
    int   errors = 0;

    keypad_4x4_encoder #(.SCAN_HOLD(3), .DEBOUNCE_MS(20), .RELEASE_MS(20)) dut (
        .clk1kHz      (clk1kHz),
        .rst          (rst),
        .filas        (filas),
        .columnas     (columnas),
        .CSseg        (CSseg),
        .tipo         (tipo),
        .codigo       (codigo),
        .tecla_valida (tecla_valida)
    );

    always #5 clk1kHz = ~clk1kHz;

    // Passive matrix: a row is pulled low when a pressed key connects it to
    // the column currently driven low.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk1kHz) begin
        if (!rst && tecla_valida) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual seg=%b tipo=%b codigo=%0d required none",
                         CSseg, tipo, codigo);
            end else begin
                exp_e = exp_q.pop_front();
                if ({CSseg, tipo, codigo} !== exp_e) begin
                    errors++;
                    $display("FAIL strobe_value actual seg=%b tipo=%b codigo=%0d required seg=%b tipo=%b codigo=%0d",
                             CSseg, tipo, codigo, exp_e.seg, exp_e.tipo, exp_e.code);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk1kHz);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [6:0] seg, input logic t, input logic [3:0] code);
        exp_t e;
        e.seg  = seg;
        e.tipo = t;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic press(input int r, input int c);
        keys[r*4+c] = 1'b1;
    endtask

    task automatic release_all();
        keys = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_CSseg"},    32'(CSseg),        32'h7F);
        chk({tag, "_tipo"},     32'(tipo),         32'h0);
        chk({tag, "_codigo"},   32'(codigo),       32'h0);
        chk({tag, "_columnas"}, 32'(columnas),     32'hE);
        chk({tag, "_strobe"},   32'(tecla_valida), 32'h0);
    endtask

    initial begin
        logic [3:0] seen;
        logic       found;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        // '5' held 60 cycles: one pulse, column parked through release window
        push(7'b0100100, 1'b1, 4'd5);
        press(1, 1);
        tick(59);
        chk("key5_parked_held", 32'(columnas), 32'hD);
        tick(1);
        release_all();
        tick(10);
        chk("key5_parked_release", 32'(columnas), 32'hD);
        tick(30);
        chk("key5_q_empty", exp_q.size(), 0);

        // 'A' bouncing 8 low / 2 high x5, then steady
        for (int i = 0; i < 5; i++) begin
            press(0, 3);
            tick(8);
            release_all();
            tick(2);
        end
        chk("keyA_no_bounce_pulse", exp_q.size(), 0);
        push(7'b1101100, 1'b0, 4'd10);
        press(0, 3);
        tick(45);
        release_all();
        tick(30);
        chk("keyA_q_empty", exp_q.size(), 0);

        // '7' twice with 25 released cycles between: two pulses
        push(7'b0001111, 1'b1, 4'd7);
        push(7'b0001111, 1'b1, 4'd7);
        press(2, 0);
        tick(40);
        release_all();
        tick(25);
        press(2, 0);
        tick(40);
        release_all();
        tick(30);
        chk("key7_twice_q_empty", exp_q.size(), 0);

        // '7' re-pressed after only 10 released cycles: merged, one pulse
        push(7'b0001111, 1'b1, 4'd7);
        press(2, 0);
        tick(40);
        release_all();
        tick(10);
        press(2, 0);
        tick(40);
        release_all();
        tick(30);
        chk("key7_merged_q_empty", exp_q.size(), 0);

        // Rows 0 and 2 on column 2: lowest row ('3') wins
        push(7'b0000110, 1'b1, 4'd3);
        press(0, 2);
        press(2, 2);
        tick(40);
        release_all();
        tick(30);
        chk("multi_q_empty", exp_q.size(), 0);

        // '#' held 50 cycles: no strobe, outputs keep the prior key
        press(3, 2);
        tick(50);
        release_all();
        tick(30);
        chk("hash_q_empty", exp_q.size(), 0);
        chk("hash_CSseg",  32'(CSseg),  32'h06);
        chk("hash_tipo",   32'(tipo),   32'h1);
        chk("hash_codigo", 32'(codigo), 32'h3);
        seen = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 4; c++)
                if (!columnas[c]) seen[c] = 1'b1;
            tick(1);
        end
        chk("hash_scan_resumed", 32'(seen), 32'hF);

        // '9' with reset asserted partway through its debounce
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (columnas == 4'b1011) found = 1'b1;
            else tick(1);
        end
        chk("key9_col2_reached", 32'(found), 32'h1);
        press(2, 2);
        tick(13);
        rst = 1'b1;
        #1;
        chk_reset_outputs("key9_rst");
        tick(3);
        release_all();
        tick(1);
        rst = 1'b0;
        tick(40);
        chk("key9_no_strobe", exp_q.size(), 0);
        chk("key9_CSseg_blank", 32'(CSseg), 32'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
